// File: rtl/kmeans_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kmeans_pkg
// Description : Shared constants, types and helpers for the k-means
//               centroid-update and convergence blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package kmeans_pkg;

    localparam int CENTROID_NUM    = 8;                          // centroids per iteration
    localparam int LOG2_CENT_NUM   = 3;                          // centroid index width
    localparam int CORDINATE_WIDTH = 13;                         // unsigned coordinate width
    localparam int COORD_NUM       = 7;                          // coordinates per centroid
    localparam int DATA_WIDTH      = COORD_NUM * CORDINATE_WIDTH; // packed centroid (91)
    localparam int MANHATTEN_WIDTH = 16;                         // distance / threshold width
    localparam int IT_WIDTH        = 10;                         // iteration counter width
    localparam int CNT_WIDTH       = 4;                          // holds 0..CENTROID_NUM

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        REPORT = 2'd2
    } conv_state_t;

    // One-hot decode of a centroid index into a write strobe.
    function automatic logic [CENTROID_NUM-1:0] idx_onehot(input logic [LOG2_CENT_NUM-1:0] idx);
        logic [CENTROID_NUM-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/manhattan_dist.sv
`default_nettype none
// ============================================================================
// Module      : manhattan_dist
// Description : Registers the per-coordinate absolute differences of two
//               packed centroids on load_i, and presents their sum (the
//               Manhattan distance) combinationally from those registers.
// Ports       : clk, rst_n   - clock, async active-low reset
//               load_i       - capture differences of a_i / b_i
//               a_i, b_i     - packed centroids (coordinate i at [13i+12:13i])
//               dist_o       - 16-bit distance of the last captured pair
// Revision    : 1.0 - initial release
// ============================================================================
module manhattan_dist
    import kmeans_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_i,
    input  logic [DATA_WIDTH-1:0]      a_i,
    input  logic [DATA_WIDTH-1:0]      b_i,
    output logic [MANHATTEN_WIDTH-1:0] dist_o
);

    localparam int EXT = MANHATTEN_WIDTH - CORDINATE_WIDTH;

    logic [DATA_WIDTH-1:0] diffs_w;

    for (genvar i = 0; i < COORD_NUM; i++) begin : g_coord
        logic [CORDINATE_WIDTH-1:0] a_c;
        logic [CORDINATE_WIDTH-1:0] b_c;
        logic [CORDINATE_WIDTH-1:0] diff_d;
        logic [CORDINATE_WIDTH-1:0] diff_q;

        assign a_c = a_i[i*CORDINATE_WIDTH +: CORDINATE_WIDTH];
        assign b_c = b_i[i*CORDINATE_WIDTH +: CORDINATE_WIDTH];

        // Subtract the smaller from the larger so the result never wraps.
        assign diff_d = (a_c >= b_c) ? (a_c - b_c) : (b_c - a_c);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                diff_q <= '0;
            end else if (load_i) begin
                diff_q <= diff_d;
            end
        end

        assign diffs_w[i*CORDINATE_WIDTH +: CORDINATE_WIDTH] = diff_q;
    end

    // 7 x 8191 = 57337 fits in 16 bits, so the plain sum cannot overflow.
    always_comb begin
        dist_o = '0;
        for (int i = 0; i < COORD_NUM; i++) begin
            dist_o = dist_o + {{EXT{1'b0}}, diffs_w[i*CORDINATE_WIDTH +: CORDINATE_WIDTH]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/cent_convergence_check.sv
`default_nettype none
// ============================================================================
// Module      : cent_convergence_check
// Description : Samples the 8 new centroids of a k-means iteration, writes
//               each back to the classification block and measures its
//               Manhattan distance to the previous value. After the 8th
//               centroid it issues one verdict: converged when every distance
//               is within threshold or when the iteration limit is reached.
// Ports       : clk, rst_n              - clock, async active-low reset
//               regs_reset_n            - sync clear of the iteration state
//               iter_clr                - sync clear of iter_cnt
//               sample_en,new_cent_valid- sample qualifiers
//               new_cent, old_cent      - new / previous centroid
//               cent_idx                - index of new_cent
//               threshold, max_iter     - distance limit, iteration limit (0=off)
//               cent_wr_en, cent_wr_data- one-cycle write-back to centroid regs
//               has_converged           - verdict (held until next verdict/clear)
//               converge_res_available  - one-cycle verdict strobe
//               iter_cnt                - completed iterations (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module cent_convergence_check
    import kmeans_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       regs_reset_n,
    input  logic                       iter_clr,
    input  logic                       sample_en,
    input  logic                       new_cent_valid,
    input  logic [DATA_WIDTH-1:0]      new_cent,
    input  logic [DATA_WIDTH-1:0]      old_cent,
    input  logic [LOG2_CENT_NUM-1:0]   cent_idx,
    input  logic [MANHATTEN_WIDTH-1:0] threshold,
    input  logic [IT_WIDTH-1:0]        max_iter,
    output logic [CENTROID_NUM-1:0]    cent_wr_en,
    output logic [DATA_WIDTH-1:0]      cent_wr_data,
    output logic                       has_converged,
    output logic                       converge_res_available,
    output logic [IT_WIDTH-1:0]        iter_cnt
);

    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(CENTROID_NUM);
    localparam logic [IT_WIDTH-1:0]  ITER_MAX = {IT_WIDTH{1'b1}};

    // ---------------------------------------------------------------- state
    conv_state_t                state_q, state_d;

    // Stage 1: captured at the accept edge
    logic                       s1_valid_q, s1_valid_d;
    logic [LOG2_CENT_NUM-1:0]   s1_idx_q, s1_idx_d;
    logic [DATA_WIDTH-1:0]      s1_cent_q, s1_cent_d;

    // Stage 2: write-back and convergence accumulation
    logic [CENTROID_NUM-1:0]    wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0]      wr_data_q, wr_data_d;
    logic                       all_conv_q, all_conv_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;

    // Verdict
    logic                       has_conv_q, has_conv_d;
    logic                       avail_q, avail_d;
    logic [IT_WIDTH-1:0]        iter_q, iter_d;

    // ---------------------------------------------------------------- wires
    logic                       accept;
    logic                       s2_fire;
    logic                       enter_report;
    logic                       dist_ok;
    logic                       iter_limit;
    logic [MANHATTEN_WIDTH-1:0] dist_w;

    // A clear request outranks a simultaneous sample.
    assign accept  = sample_en & new_cent_valid & (state_q != REPORT) & regs_reset_n;
    assign s2_fire = s1_valid_q & regs_reset_n;
    assign dist_ok = (dist_w <= threshold);

    // Compare in one extra bit so iter_q + 1 cannot wrap at all-ones.
    assign iter_limit = (max_iter != '0) &&
                        (({1'b0, iter_q} + (IT_WIDTH+1)'(1)) >= {1'b0, max_iter});

    manhattan_dist u_dist (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (accept),
        .a_i    (new_cent),
        .b_i    (old_cent),
        .dist_o (dist_w)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        enter_report = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // cnt_q reaches 8 on the edge the 8th sample leaves stage 2.
                if (cnt_q >= FULL_CNT) begin
                    state_d      = REPORT;
                    enter_report = 1'b1;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!regs_reset_n) begin
            state_d      = IDLE;
            enter_report = 1'b0;
        end
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        s1_valid_d = accept;
        s1_idx_d   = accept ? cent_idx : s1_idx_q;
        s1_cent_d  = accept ? new_cent : s1_cent_q;

        wr_en_d    = s2_fire ? idx_onehot(s1_idx_q) : '0;
        wr_data_d  = s2_fire ? s1_cent_q : '0;

        cnt_d      = cnt_q;
        all_conv_d = all_conv_q;
        if (!regs_reset_n) begin
            cnt_d      = '0;
            all_conv_d = 1'b1;
        end else if (state_q == REPORT) begin
            // Leaving REPORT restarts accumulation; a sample already in
            // stage 2 on this edge opens the next iteration.
            cnt_d      = s2_fire ? CNT_WIDTH'(1) : '0;
            all_conv_d = s2_fire ? dist_ok : 1'b1;
        end else if (s2_fire) begin
            cnt_d      = cnt_q + CNT_WIDTH'(1);
            all_conv_d = all_conv_q & dist_ok;
        end

        avail_d = enter_report;

        has_conv_d = has_conv_q;
        if (!regs_reset_n) begin
            has_conv_d = 1'b0;
        end else if (enter_report) begin
            has_conv_d = all_conv_q | iter_limit;
        end

        iter_d = iter_q;
        if (iter_clr) begin
            iter_d = '0;
        end else if (enter_report && (iter_q != ITER_MAX)) begin
            iter_d = iter_q + IT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_cent_q  <= '0;
            wr_en_q    <= '0;
            wr_data_q  <= '0;
            all_conv_q <= 1'b1;
            cnt_q      <= '0;
            has_conv_q <= 1'b0;
            avail_q    <= 1'b0;
            iter_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_idx_q   <= s1_idx_d;
            s1_cent_q  <= s1_cent_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            all_conv_q <= all_conv_d;
            cnt_q      <= cnt_d;
            has_conv_q <= has_conv_d;
            avail_q    <= avail_d;
            iter_q     <= iter_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign cent_wr_en             = wr_en_q;
    assign cent_wr_data           = wr_data_q;
    assign has_converged          = has_conv_q;
    assign converge_res_available = avail_q;
    assign iter_cnt               = iter_q;

endmodule
`default_nettype wire
